// File: rtl/imem_loader.sv
// Instruction memory for the single-cycle core: zero-latency fetch port plus a
// byte-serial boot loader that packs bytes little-endian and holds the core in reset.
module imem_loader #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_IM_addr,
  output logic [31:0] o_IM_instruction,
  input  logic        i_ld_start,
  input  logic        i_ld_valid,
  input  logic [7:0]  i_ld_byte,
  input  logic        i_ld_last,
  output logic        o_ld_ready,
  output logic        o_ld_done,
  output logic        o_core_rstn
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LastIdx = (AW + 1)'(DEPTH - 1);

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      r_state, w_state_d;
  logic [AW:0] r_word_idx, w_word_idx_d;
  logic [1:0]  r_byte_cnt, w_byte_cnt_d;
  logic [23:0] r_asm, w_asm_d;

  data_t       r_mem [DEPTH];

  logic          w_accept;
  logic          w_wr_en;
  data_t         w_wr_data;
  logic [AW-1:0] w_wr_addr;

  addr_t         w_fetch_addr;
  logic [AW-1:0] w_fetch_idx;
  logic          w_in_range;
  logic          w_unused_addr;

  // Status outputs

  assign o_ld_ready  = i_rstn && (r_state == StLoad);
  assign o_ld_done   = i_rstn && (r_state == StDone);
  assign o_core_rstn = i_rstn && (r_state == StIdle);

  assign w_accept  = i_ld_valid && o_ld_ready;
  assign w_wr_addr = r_word_idx[AW-1:0];

  // Next-state logic

  always_comb begin
    w_state_d    = r_state;
    w_word_idx_d = r_word_idx;
    w_byte_cnt_d = r_byte_cnt;
    w_asm_d      = r_asm;
    w_wr_en      = 1'b0;
    w_wr_data    = '0;

    // Unfilled upper bytes of asm are always zero, so a short final word is zero-padded.
    unique case (r_byte_cnt)
      2'd0:    w_wr_data = {24'h0, i_ld_byte};
      2'd1:    w_wr_data = {16'h0, i_ld_byte, r_asm[7:0]};
      2'd2:    w_wr_data = {8'h0, i_ld_byte, r_asm[15:0]};
      default: w_wr_data = {i_ld_byte, r_asm[23:0]};
    endcase

    unique case (r_state)
      StIdle: begin
        if (i_ld_start) begin
          w_state_d    = StLoad;
          w_word_idx_d = '0;
          w_byte_cnt_d = '0;
          w_asm_d      = '0;
        end
      end
      StLoad: begin
        if (w_accept) begin
          w_byte_cnt_d = r_byte_cnt + 2'd1;
          if (r_byte_cnt != 2'd3) begin
            w_asm_d[8*r_byte_cnt +: 8] = i_ld_byte;
          end
          if (i_ld_last || (r_byte_cnt == 2'd3)) begin
            w_wr_en      = 1'b1;
            w_asm_d      = '0;
            w_word_idx_d = r_word_idx + 1'b1;
            if (i_ld_last || (r_word_idx == LastIdx)) begin
              w_state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State registers

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= StIdle;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_word_idx <= w_word_idx_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_asm      <= w_asm_d;
    end
  end

  // Memory contents survive reset; the write is gated so a byte on the reset edge is dropped.
  always_ff @(posedge i_clk) begin
    if (w_wr_en && i_rstn) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Fetch port

  assign w_fetch_addr  = i_IM_addr;
  assign w_fetch_idx   = w_fetch_addr[AW+1:2];
  assign w_in_range    = (w_fetch_addr[31:AW+2] == '0);
  assign w_unused_addr = ^w_fetch_addr[1:0];

  always_comb begin
    o_IM_instruction = NOP_WORD;
    if (i_rstn && (r_state == StIdle) && w_in_range) begin
      o_IM_instruction = r_mem[w_fetch_idx];
    end
  end

endmodule
